// File: rtl/sram_like_arbiter.sv
// Round-robin arbiter merging NCH sram-like masters onto one downstream port.
// Responses are routed back in acceptance order through an order FIFO of channel indices.
module sram_like_arbiter #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned OUTSTANDING = 4,
  parameter int unsigned DW          = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NCH-1:0]                   m_req,
  input  logic [NCH-1:0]                   m_wr,
  input  logic [2*NCH-1:0]                 m_size,
  input  logic [4*NCH-1:0]                 m_wstrb,
  input  logic [DW*NCH-1:0]                m_addr,
  input  logic [DW*NCH-1:0]                m_wdata,
  output logic [NCH-1:0]                   m_addr_ok,
  output logic [NCH-1:0]                   m_data_ok,
  output logic [DW-1:0]                    m_rdata,
  output logic                             s_req,
  output logic                             s_wr,
  output logic [1:0]                       s_size,
  output logic [3:0]                       s_wstrb,
  output logic [DW-1:0]                    s_addr,
  output logic [DW-1:0]                    s_wdata,
  input  logic                             s_addr_ok,
  input  logic                             s_data_ok,
  input  logic [DW-1:0]                    s_rdata,
  output logic [$clog2(OUTSTANDING+1)-1:0] outst_cnt,
  output logic                             err_unexp
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);
  localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [IW-1:0]   lock_ch;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_grant;
  logic            rr_found;
  logic [IW-1:0]   grant;
  logic            sel_req;
  logic            full;
  logic            accept;
  logic            pop;
  logic [IW-1:0]   fifo [OUTSTANDING];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [IW:0]     cand;

  // Round-robin search: candidate = (rr_ptr + k) mod NCH, first requester wins.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NCH)) cand = cand - (IW+1)'(NCH);
      if (!rr_found && m_req[cand[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_grant = cand[IW-1:0];
      end
    end
  end

  assign grant   = (state == LOCK) ? lock_ch : rr_grant;
  assign sel_req = (state == LOCK) ? m_req[lock_ch] : rr_found;
  assign full    = (outst_cnt == CW'(OUTSTANDING));
  assign s_req   = !reset && sel_req && !full;
  assign accept  = s_req && s_addr_ok;
  assign pop     = !reset && s_data_ok && (outst_cnt != '0);
  assign m_rdata = s_rdata;

  always_comb begin
    s_wr      = 1'b0;
    s_size    = '0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (grant == IW'(k)) begin
        s_wr         = m_wr[k];
        s_size       = m_size[2*k +: 2];
        s_wstrb      = m_wstrb[4*k +: 4];
        s_addr       = m_addr[DW*k +: DW];
        s_wdata      = m_wdata[DW*k +: DW];
        m_addr_ok[k] = accept;
      end
      if (pop && fifo[head] == IW'(k)) m_data_ok[k] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lock_ch   <= '0;
      rr_ptr    <= '0;
      head      <= '0;
      tail      <= '0;
      outst_cnt <= '0;
      err_unexp <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_req && !s_addr_ok) begin
          state   <= LOCK;
          lock_ch <= rr_grant;
        end
        // A master withdrawing its request also releases the lock.
        LOCK: if (!s_req || s_addr_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (accept) begin
        fifo[tail] <= grant;
        tail       <= (tail == PW'(OUTSTANDING-1)) ? '0 : tail + 1'b1;
        rr_ptr     <= (grant == IW'(NCH-1)) ? '0 : grant + 1'b1;
      end
      if (pop) head <= (head == PW'(OUTSTANDING-1)) ? '0 : head + 1'b1;
      case ({accept, pop})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
      if (s_data_ok && outst_cnt == '0) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: instance a (NCH=2) and instance b (NCH=4), both OUTSTANDING=4.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [1:0]  a_req, a_wr, a_aok, a_dok;
  logic [3:0]  a_size;
  logic [7:0]  a_wstrb;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic        a_s_req, a_s_wr, a_s_aok, a_s_dok, a_err;
  logic [1:0]  a_s_size;
  logic [3:0]  a_s_wstrb;
  logic [2:0]  a_cnt;

  logic [3:0]   b_req, b_wr, b_aok, b_dok;
  logic [7:0]   b_size;
  logic [15:0]  b_wstrb;
  logic [127:0] b_addr, b_wdata;
  logic [31:0]  b_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic         b_s_req, b_s_wr, b_s_aok, b_s_dok, b_err;
  logic [1:0]   b_s_size;
  logic [3:0]   b_s_wstrb;
  logic [2:0]   b_cnt;

  sram_like_arbiter #(.NCH(2), .OUTSTANDING(4), .DW(32)) dut_a (
    .clk(clk), .reset(reset),
    .m_req(a_req), .m_wr(a_wr), .m_size(a_size), .m_wstrb(a_wstrb),
    .m_addr(a_addr), .m_wdata(a_wdata),
    .m_addr_ok(a_aok), .m_data_ok(a_dok), .m_rdata(a_rdata),
    .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_wstrb(a_s_wstrb),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_addr_ok(a_s_aok), .s_data_ok(a_s_dok), .s_rdata(a_s_rdata),
    .outst_cnt(a_cnt), .err_unexp(a_err)
  );

  sram_like_arbiter #(.NCH(4), .OUTSTANDING(4), .DW(32)) dut_b (
    .clk(clk), .reset(reset),
    .m_req(b_req), .m_wr(b_wr), .m_size(b_size), .m_wstrb(b_wstrb),
    .m_addr(b_addr), .m_wdata(b_wdata),
    .m_addr_ok(b_aok), .m_data_ok(b_dok), .m_rdata(b_rdata),
    .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_wstrb(b_s_wstrb),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_addr_ok(b_s_aok), .s_data_ok(b_s_dok), .s_rdata(b_s_rdata),
    .outst_cnt(b_cnt), .err_unexp(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    a_req = 2'b11; a_wr = 2'b10; a_size = 4'b1001; a_wstrb = 8'hF3;
    a_addr = {32'h0000_00B1, 32'h0000_00A0};
    a_wdata = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
    a_s_aok = 1'b1; a_s_dok = 1'b0; a_s_rdata = '0;
    b_req = 4'b1111; b_wr = '0; b_size = '0; b_wstrb = '0;
    b_addr = {32'h33, 32'h22, 32'h11, 32'h00}; b_wdata = '0;
    b_s_aok = 1'b0; b_s_dok = 1'b0; b_s_rdata = '0;

    // Reset behaviour
    @(negedge clk); #1;
    chk("rst_sreq", a_s_req, 0);
    chk("rst_aok", a_aok, 0);
    chk("rst_b_sreq", b_s_req, 0);
    @(negedge clk); #1;
    chk("rst_cnt", a_cnt, 0);
    chk("rst_err", a_err, 0);

    // Round-robin with one-cycle returns
    @(negedge clk); reset = 1'b0; b_req = '0; #1;
    chk("rr0_aok", a_aok, 2'b01);
    chk("rr0_addr", a_s_addr, 32'hA0);
    chk("rr0_dok", a_dok, 2'b00);
    @(negedge clk); a_s_dok = 1'b1; a_s_rdata = 32'h1111_2222; #1;
    chk("rr1_aok", a_aok, 2'b10);
    chk("rr1_addr", a_s_addr, 32'hB1);
    chk("rr1_dok", a_dok, 2'b01);
    chk("rr1_rdata", a_rdata, 32'h1111_2222);
    @(negedge clk); #1;
    chk("rr2_aok", a_aok, 2'b01);
    chk("rr2_dok", a_dok, 2'b10);
    @(negedge clk); #1;
    chk("rr3_aok", a_aok, 2'b10);
    chk("rr3_dok", a_dok, 2'b01);
    @(negedge clk); a_req = 2'b00; #1;
    chk("rr4_sreq", a_s_req, 0);
    chk("rr4_dok", a_dok, 2'b10);
    @(negedge clk); a_s_dok = 1'b0; #1;
    chk("rr_cnt0", a_cnt, 0);

    // Lock on ch1 while ch0 also requests
    @(negedge clk); a_req = 2'b10; a_s_aok = 1'b0; #1;
    chk("lk0_sreq", a_s_req, 1);
    chk("lk0_addr", a_s_addr, 32'hB1);
    chk("lk0_wr", a_s_wr, 1);
    chk("lk0_size", a_s_size, 2'b10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); a_req = 2'b11; #1;
      chk("lk_addr", a_s_addr, 32'hB1);
      chk("lk_wdata", a_s_wdata, 32'hD1D1_D1D1);
      chk("lk_aok", a_aok, 2'b00);
    end
    @(negedge clk); a_s_aok = 1'b1; #1;
    chk("lk3_addr", a_s_addr, 32'hB1);
    chk("lk3_aok", a_aok, 2'b10);
    @(negedge clk); a_req = 2'b00; a_s_dok = 1'b1; #1;
    chk("lk_ret", a_dok, 2'b10);

    // Locked master drops its request: lock released, no push
    @(negedge clk); a_s_dok = 1'b0; a_req = 2'b01; a_s_aok = 1'b0; #1;
    chk("drop0_addr", a_s_addr, 32'hA0);
    @(negedge clk); a_req = 2'b10; #1;
    chk("drop1_sreq", a_s_req, 0);
    chk("drop1_aok", a_aok, 2'b00);
    @(negedge clk); a_s_aok = 1'b1; #1;
    chk("drop2_aok", a_aok, 2'b10);
    chk("drop2_cnt", a_cnt, 0);
    @(negedge clk); a_req = 2'b00; a_s_dok = 1'b1; #1;
    chk("drop_ret", a_dok, 2'b10);
    @(negedge clk); a_s_dok = 1'b0; #1;
    chk("drop_cnt", a_cnt, 0);

    // Fill to OUTSTANDING, then pop while full
    @(negedge clk); a_req = 2'b01; #1;
    chk("fill_aok", a_aok, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("fill_aok", a_aok, 2'b01);
    end
    @(negedge clk); #1;
    chk("full_cnt", a_cnt, 4);
    chk("full_sreq", a_s_req, 0);
    chk("full_aok", a_aok, 2'b00);
    @(negedge clk); a_s_dok = 1'b1; #1;
    chk("fullpop_dok", a_dok, 2'b01);
    chk("fullpop_sreq", a_s_req, 0);
    chk("fullpop_aok", a_aok, 2'b00);
    @(negedge clk); a_s_dok = 1'b0; #1;
    chk("resume_cnt", a_cnt, 3);
    chk("resume_sreq", a_s_req, 1);
    chk("resume_aok", a_aok, 2'b01);
    @(negedge clk); a_req = 2'b00; a_s_dok = 1'b1; #1;
    chk("refull_cnt", a_cnt, 4);
    chk("drain_dok", a_dok, 2'b01);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("drain_dok", a_dok, 2'b01);
    end
    @(negedge clk); a_s_dok = 1'b0; #1;
    chk("drain_cnt", a_cnt, 0);

    // Unexpected return is sticky
    @(negedge clk); a_s_dok = 1'b1; #1;
    chk("unexp_dok", a_dok, 2'b00);
    @(negedge clk); a_s_dok = 1'b0; #1;
    chk("unexp_err", a_err, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("unexp_hold", a_err, 1);
    @(negedge clk); reset = 1'b1; #1;
    @(negedge clk); reset = 1'b0; #1;
    chk("unexp_clr", a_err, 0);

    // NCH=4 ordering
    @(negedge clk); b_req = 4'b1000; b_s_aok = 1'b1; #1;
    chk("b_acc3", b_aok, 4'b1000);
    chk("b_addr3", b_s_addr, 32'h33);
    @(negedge clk); b_req = 4'b0010; #1;
    chk("b_acc1", b_aok, 4'b0010);
    @(negedge clk); b_req = 4'b0100; #1;
    chk("b_acc2", b_aok, 4'b0100);
    @(negedge clk); b_req = 4'b0000; b_s_dok = 1'b1; #1;
    chk("b_ret3", b_dok, 4'b1000);
    @(negedge clk); #1;
    chk("b_ret1", b_dok, 4'b0010);
    @(negedge clk); #1;
    chk("b_ret2", b_dok, 4'b0100);
    @(negedge clk); b_s_dok = 1'b0; b_req = 4'b0001; #1;
    chk("b_wrap_aok", b_aok, 4'b0001);
    @(negedge clk); #1;
    chk("b_acc0", b_aok, 4'b0001);
    @(negedge clk); b_req = 4'b0000; #1;
    chk("b_cnt2", b_cnt, 2);
    @(negedge clk); reset = 1'b1; b_s_dok = 1'b1; #1;
    chk("b_rst_dok", b_dok, 4'b0000);
    @(negedge clk); reset = 1'b0; #1;
    chk("b_rst_cnt", b_cnt, 0);
    chk("b_late_dok", b_dok, 4'b0000);
    chk("b_rst_err", b_err, 0);
    @(negedge clk); b_s_dok = 1'b0; #1;
    chk("b_late_err", b_err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
